// File: rtl/decode_execute_stage.sv
// Decode-to-execute pipeline register with a one-entry skid buffer.
// in_ready is a flop, so it has no combinational path from out_ready.
module decode_execute_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flushE,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] rd1D,
  input  logic [DATA_WIDTH-1:0] rd2D,
  input  logic [DATA_WIDTH-1:0] PCounterD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [DATA_WIDTH-1:0] ImmOpD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic [CTRL_WIDTH-1:0] CtrlD,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rd1E,
  output logic [DATA_WIDTH-1:0] rd2E,
  output logic [DATA_WIDTH-1:0] PCounterE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [DATA_WIDTH-1:0] ImmOpE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [CTRL_WIDTH-1:0] CtrlE,
  output logic [15:0]           bubble_cnt
);

  localparam int unsigned PW = 5 * DATA_WIDTH + 3 * REG_ADDR_W + CTRL_WIDTH;

  // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  occ_e          state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   bubble_cnt_q, bubble_cnt_d;
  logic [PW-1:0] in_payload;
  logic          main_valid;
  logic          in_hs;
  logic          out_hs;

  assign in_payload = {rd1D, rd2D, PCounterD, PCPlus4D, ImmOpD, Rs1D, Rs2D, RdD, CtrlD};
  assign {rd1E, rd2E, PCounterE, PCPlus4E, ImmOpE, Rs1E, Rs2E, RdE, CtrlE} = main_q;

  assign main_valid = (state_q != EMPTY);
  assign out_valid  = main_valid;
  assign in_ready   = in_ready_q;
  assign bubble_cnt = bubble_cnt_q;
  assign in_hs      = in_valid & in_ready_q;
  assign out_hs     = main_valid & out_ready;

  // Next occupancy and payload; flush wins over any handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flushE) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            main_d  = in_payload;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_d = in_payload;
          end else if (in_hs) begin
            skid_d  = in_payload;
            state_d = FULL;
          end else if (out_hs) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // ready mirrors "skid not valid" one cycle ahead, so it can be a flop
    in_ready_d = (state_d != FULL);
  end

  // Saturating count of cycles where execute was ready but nothing was offered
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !main_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // State, payload and counter registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: accepted entries are queued,
// and a monitor pops and compares every output handshake.
module tb_decode_execute_stage;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flushE = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] bubble_cnt;
  ent_t        drv = '0;
  logic [31:0] rd1E, rd2E, PCounterE, PCPlus4E, ImmOpE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] CtrlE;
  ent_t        act;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned acc_cnt = 0;
  ent_t        exp_q[$];

  assign act = {rd1E, rd2E, PCounterE, PCPlus4E, ImmOpE, Rs1E, Rs2E, RdE, CtrlE};

  decode_execute_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5), .CTRL_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flushE(flushE),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd1D(drv.rd1), .rd2D(drv.rd2), .PCounterD(drv.pc), .PCPlus4D(drv.pc4),
    .ImmOpD(drv.imm), .Rs1D(drv.rs1), .Rs2D(drv.rs2), .RdD(drv.rd), .CtrlD(drv.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd1E(rd1E), .rd2E(rd2E), .PCounterE(PCounterE), .PCPlus4E(PCPlus4E),
    .ImmOpE(ImmOpE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic ent_t mk(input int unsigned id);
    ent_t e;
    e.rd1  = 32'hA000_0000 + id;
    e.rd2  = 32'hB000_0000 + id;
    e.pc   = 32'h0000_0100 + id * 4;
    e.pc4  = 32'h0000_0104 + id * 4;
    e.imm  = 32'hFFFF_FF00 + id;
    e.rs1  = 5'(id);
    e.rs2  = 5'(id + 7);
    e.rd   = 5'(id + 13);
    e.ctrl = 16'hC000 + 16'(id);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Acceptance side of the scoreboard: record every entry the stage takes
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready && !flushE) begin
      exp_q.push_back(drv);
      acc_cnt++;
    end
  end

  // Monitor: every output handshake must match the oldest accepted entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0h expected none", act);
      end else begin
        chk("output_entry", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    ent_t a;
    bit [6:0] pat;
    int unsigned next_id;
    int unsigned seen;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bubble", bubble_cnt, 16'd0);
    chk("rst_payload", act, '0);
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("release_in_ready", in_ready, 1'b1);

    // single entry, latency 1
    out_ready = 1'b1;
    a = mk(0);
    a.rd1 = 32'h1234;
    a.rd = 5'd5;
    drv = a;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_rd1E", rd1E, 32'h1234);
    chk("lat_RdE", RdE, 5'd5);
    cycle();
    chk("lat_drained", out_valid, 1'b0);

    // backpressure fills skid, then drains in order
    out_ready = 1'b0;
    drv = mk(1);
    in_valid = 1'b1;
    cycle();
    drv = mk(2);
    cycle();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_main_first", rd1E, 32'hA000_0001);
    cycle();
    chk("stall_hold", act, mk(1));
    out_ready = 1'b1;
    cycle();
    chk("drain_in_ready", in_ready, 1'b1);
    chk("drain_second", rd1E, 32'hA000_0002);
    cycle();
    chk("drain_empty", out_valid, 1'b0);

    // flush while FULL discards held entries and the concurrent input
    out_ready = 1'b0;
    drv = mk(3);
    in_valid = 1'b1;
    cycle();
    drv = mk(4);
    cycle();
    drv = mk(5);
    flushE = 1'b1;
    cycle();
    flushE = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_payload", act, '0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // streaming 8 entries with the consumer always ready
    for (int unsigned i = 0; i < 8; i++) begin
      drv = mk(10 + i);
      in_valid = 1'b1;
      cycle();
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_done", out_valid, 1'b0);

    // mixed backpressure: producer holds each entry until accepted
    pat = 7'b1011001;
    next_id = 20;
    for (int unsigned c = 0; c < 200 && next_id < 32; c++) begin
      seen = acc_cnt;
      drv = mk(next_id);
      in_valid = 1'b1;
      out_ready = pat[c % 7];
      cycle();
      if (acc_cnt != seen) next_id++;
    end
    chk("mixed_all_accepted", next_id, 32);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("mixed_drained", exp_q.size(), 0);

    // bubble counter: exact count, saturation, immune to flush
    rst_n = 1'b0;
    #1;
    chk("bubble_reset", bubble_cnt, 16'd0);
    exp_q.delete();
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) cycle();
    chk("bubble_ten", bubble_cnt, 16'd10);
    repeat (70000) cycle();
    chk("bubble_sat", bubble_cnt, 16'hFFFF);
    flushE = 1'b1;
    cycle();
    flushE = 1'b0;
    chk("bubble_flush_keep", bubble_cnt, 16'hFFFF);

    // asynchronous reset while FULL clears outputs before the next edge
    out_ready = 1'b0;
    drv = mk(40);
    in_valid = 1'b1;
    cycle();
    drv = mk(41);
    cycle();
    in_valid = 1'b0;
    chk("pre_areset_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_payload", act, '0);
    chk("areset_in_ready", in_ready, 1'b1);
    exp_q.delete();
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("post_areset_empty", out_valid, 1'b0);

    chk("queue_empty_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_execute_stage.md
DECODE_EXECUTE_STAGE -- requirements
Module: decode_execute_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the operand, PC, PC+4 and immediate fields.
REQ-002 Parameter REG_ADDR_W, default 5: width of each register-index field.
REQ-003 Parameter CTRL_WIDTH, default 16: width of the opaque control bundle.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port flushE, input, 1: synchronous flush; discards all held entries.
REQ-007 Port in_valid, input, 1: producer (decode) offers an entry this cycle.
REQ-008 Port in_ready, output, 1: stage can accept an entry this cycle.
REQ-009 Ports rd1D, rd2D, PCounterD, PCPlus4D, ImmOpD, input, DATA_WIDTH each: decode payload.
REQ-010 Ports Rs1D, Rs2D, RdD, input, REG_ADDR_W each: register indices.
REQ-011 Port CtrlD, input, CTRL_WIDTH: control bundle.
REQ-012 Port out_valid, output, 1: an entry is presented to execute.
REQ-013 Port out_ready, input, 1: consumer (execute) accepts the presented entry.
REQ-014 Ports rd1E, rd2E, PCounterE, PCPlus4E, ImmOpE, Rs1E, Rs2E, RdE, CtrlE, output: the presented entry, same widths as the D-side ports.
REQ-015 Port bubble_cnt, output, 16: count of cycles with out_ready=1 and out_valid=0.

Function
REQ-016 An input handshake occurs when in_valid and in_ready are both 1; an output handshake occurs when out_valid and out_ready are both 1.
REQ-017 Storage is one main register (drives the E ports) plus one skid register, each holding the full payload and a valid bit.
REQ-018 Occupancy state shall be one of EMPTY (no valid entries), ONE (main valid only) or FULL (main and skid valid).
REQ-019 in_ready shall be 1 exactly when the skid register is not valid, registered with no combinational path from out_ready.
REQ-020 out_valid shall equal the main valid bit.
REQ-021 EMPTY: input handshake loads main and goes to ONE, giving a latency of 1 cycle from input handshake to out_valid.
REQ-022 ONE, input handshake without output handshake: load skid and go to FULL.
REQ-023 ONE, input and output handshake together: reload main from the inputs and stay in ONE.
REQ-024 ONE, output handshake only: go to EMPTY; payload fields hold their last values.
REQ-025 FULL, output handshake: copy skid into main, clear the skid valid bit and go to ONE (in_ready=0 in FULL, so no input is accepted).
REQ-026 With no handshake, all held state shall be unchanged; this is the stall case.
REQ-027 flushE=1 shall force EMPTY at the next edge, clear both valid bits and zero all payload fields in main and skid.
REQ-028 flushE overrides everything: an input handshake in the same cycle is discarded, and an output handshake in the same cycle still counts as consumed.
REQ-029 Entries shall leave the stage in acceptance order; none shall be lost except by flush, and none shall be duplicated.
REQ-030 bubble_cnt shall increment by 1 per qualifying cycle, saturate at 0xFFFF, and not be cleared by flushE.

Reset
REQ-031 While rst_n=0, state shall be EMPTY, both valid bits 0, all payload outputs 0, and bubble_cnt 0.
REQ-032 in_ready shall be 1 while rst_n=0 and on the first cycle after release.
REQ-033 Reset asserted mid-operation shall discard held entries immediately, without waiting for a clock edge.

Verification
REQ-034 Reset release, out_ready=1, one input with rd1D=0x1234, RdD=5 -> next cycle out_valid=1, rd1E=0x1234, RdE=5; the following cycle out_valid=0.
REQ-035 out_ready=0, inputs A then B on consecutive cycles -> in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready back to 1 once the skid drains.
REQ-036 FULL with A and B held, flushE=1 with in_valid=1 carrying C -> next cycle out_valid=0, all E outputs 0, C never appears.
REQ-037 Streaming 8 entries, in_valid=1 and out_ready=1 every cycle -> 8 consecutive out_valid cycles, in order, in_ready never 0.
REQ-038 out_ready=1 with no input for 70000 cycles -> bubble_cnt=0xFFFF, and a flush leaves it unchanged.
REQ-039 rst_n driven low between clock edges while FULL -> out_valid and all outputs 0 immediately, before the next clock edge.
